// File: rtl/clk_reset_ce_gen.sv
// Reset sequencer and clock-enable generator for the 96 MHz PLL domain.
// Waits for a stable PLL lock, holds sys_reset while the dividers start, then runs.
module clk_reset_ce_gen #(
   parameter int unsigned LOCK_STABLE = 1024,
   parameter int unsigned RESET_HOLD  = 256,
   parameter int unsigned PIX_DIV     = 16,
   parameter int unsigned CPU_DIV     = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       soft_reset,
   output logic       sys_reset,
   output logic       ready,
   output logic       ce_pix,
   output logic       ce_pix_n,
   output logic       ce_cpu,
   output logic [1:0] dbg_state_o
);

   localparam int unsigned STW = $clog2(LOCK_STABLE);
   localparam int unsigned HW  = $clog2(RESET_HOLD);
   localparam int unsigned PW  = $clog2(PIX_DIV);
   localparam int unsigned CW  = $clog2(CPU_DIV);

   localparam logic [STW-1:0] STABLE_LAST = STW'(LOCK_STABLE - 1);
   localparam logic [HW-1:0]  HOLD_LAST   = HW'(RESET_HOLD - 1);
   localparam logic [PW-1:0]  PIX_LAST    = PW'(PIX_DIV - 1);
   localparam logic [PW-1:0]  PIX_HALF    = PW'(PIX_DIV / 2);
   localparam logic [CW-1:0]  CPU_LAST    = CW'(CPU_DIV - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   logic           sync1_q;
   logic           locked_s_q;
   state_t         state_q,      state_d;
   logic [STW-1:0] stable_cnt_q, stable_cnt_d;
   logic [HW-1:0]  hold_cnt_q,   hold_cnt_d;
   logic [PW-1:0]  pix_cnt_q,    pix_cnt_d;
   logic [CW-1:0]  cpu_cnt_q,    cpu_cnt_d;
   logic           sys_reset_q,  sys_reset_d;
   logic           ce_pix_q,     ce_pix_d;
   logic           ce_pix_n_q,   ce_pix_n_d;
   logic           ce_cpu_q,     ce_cpu_d;
   logic           clear_div;
   logic           div_run;

   // Next-state logic. Lock loss always wins over soft_reset.
   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      clear_div    = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            stable_cnt_d = '0;
            hold_cnt_d   = '0;
            if (locked_s_q) begin
               state_d = STABLE;
            end
         end
         STABLE: begin
            if (!locked_s_q) begin
               state_d = WAIT_LOCK;
            end else if (stable_cnt_q == STABLE_LAST) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
               clear_div  = 1'b1;
            end else begin
               stable_cnt_d = stable_cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!locked_s_q) begin
               state_d = WAIT_LOCK;
            end else if (soft_reset) begin
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!locked_s_q) begin
               state_d = WAIT_LOCK;
            end else if (soft_reset) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      if (state_d == WAIT_LOCK) begin
         stable_cnt_d = '0;
         hold_cnt_d   = '0;
      end
   end

   // Dividers free-run through HOLD and RUN; a soft reset leaves their phase alone.
   always_comb begin
      div_run = (state_d == HOLD) || (state_d == RUN);

      if (!div_run || clear_div) begin
         pix_cnt_d = '0;
         cpu_cnt_d = '0;
      end else begin
         pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + 1'b1;
         cpu_cnt_d = (cpu_cnt_q == CPU_LAST) ? '0 : cpu_cnt_q + 1'b1;
      end

      ce_pix_d    = div_run && (pix_cnt_d == '0);
      ce_pix_n_d  = div_run && (pix_cnt_d == PIX_HALF);
      ce_cpu_d    = div_run && (cpu_cnt_d == '0);
      sys_reset_d = (state_d != RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         locked_s_q   <= 1'b0;
         state_q      <= WAIT_LOCK;
         stable_cnt_q <= '0;
         hold_cnt_q   <= '0;
         pix_cnt_q    <= '0;
         cpu_cnt_q    <= '0;
         sys_reset_q  <= 1'b1;
         ce_pix_q     <= 1'b0;
         ce_pix_n_q   <= 1'b0;
         ce_cpu_q     <= 1'b0;
      end else begin
         sync1_q      <= pll_locked;
         locked_s_q   <= sync1_q;
         state_q      <= state_d;
         stable_cnt_q <= stable_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         pix_cnt_q    <= pix_cnt_d;
         cpu_cnt_q    <= cpu_cnt_d;
         sys_reset_q  <= sys_reset_d;
         ce_pix_q     <= ce_pix_d;
         ce_pix_n_q   <= ce_pix_n_d;
         ce_cpu_q     <= ce_cpu_d;
      end
   end

   assign sys_reset   = sys_reset_q;
   assign ready       = ~sys_reset_q;
   assign ce_pix      = ce_pix_q;
   assign ce_pix_n    = ce_pix_n_q;
   assign ce_cpu      = ce_cpu_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clk_reset_ce_gen.sv
// Bench for clk_reset_ce_gen: directed lock/reset scenarios plus random lock and
// soft-reset traffic, scored against a lock-streak/phase model of the sequencer.
module tb_clk_reset_ce_gen;

   localparam int LS = 8;
   localparam int RH = 4;
   localparam int PD = 4;
   localparam int CD = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pll_locked = 1'b0;
   logic       soft_reset = 1'b0;
   logic       sys_reset;
   logic       ready;
   logic       ce_pix;
   logic       ce_pix_n;
   logic       ce_cpu;
   logic [1:0] dbg_state_o;

   clk_reset_ce_gen #(
      .LOCK_STABLE (LS),
      .RESET_HOLD  (RH),
      .PIX_DIV     (PD),
      .CPU_DIV     (CD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pll_locked  (pll_locked),
      .soft_reset  (soft_reset),
      .sys_reset   (sys_reset),
      .ready       (ready),
      .ce_pix      (ce_pix),
      .ce_pix_n    (ce_pix_n),
      .ce_cpu      (ce_cpu),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         errors = 0;
   logic [6:0] exp_q[$];

   // Model: lock history, length of the current locked_s streak, and the edge
   // of the most recent hold (re)start. Phase of the dividers = streak - (LS+1).
   logic p1 = 1'b0;
   logic p2 = 1'b0;
   int   streak = 0;
   int   edge_n = 0;
   int   last_trig = 0;

   function automatic logic [6:0] dut_vec();
      return {dbg_state_o, sys_reset, ready, ce_pix, ce_pix_n, ce_cpu};
   endfunction

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t edge %0d: got {st,rst,rdy,pix,pixn,cpu}=%b expected %b",
                  name, $time, edge_n, act, exp);
      end
   endtask

   task automatic model_edge(input logic lk, input logic sr);
      logic       l_s;
      logic       en;
      logic       sys;
      int         ph;
      logic [1:0] st;
      l_s = p2;
      p2  = p1;
      p1  = lk;
      edge_n++;
      if (!l_s) streak = 0;
      else      streak++;
      if (streak == LS + 1)               last_trig = edge_n;
      else if (streak > LS + 1 && sr)     last_trig = edge_n;
      en  = (streak >= LS + 1);
      ph  = streak - (LS + 1);
      sys = !(en && (edge_n - last_trig >= RH));
      if (streak == 0) st = 2'd0;
      else if (!en)    st = 2'd1;
      else if (sys)    st = 2'd2;
      else             st = 2'd3;
      exp_q.push_back({st, sys, !sys,
                       en && (ph % PD == 0),
                       en && (ph % PD == PD / 2),
                       en && (ph % CD == 0)});
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input logic lk, input logic sr);
      pll_locked = lk;
      soft_reset = sr;
      @(posedge clk);
      #1;
      model_edge(lk, sr);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", dut_vec(), 7'b0010000);
      repeat (2) @(posedge clk);
      #3;
      chk("reset_held", dut_vec(), 7'b0010000);
      rst_n  = 1'b1;
      p1     = 1'b0;
      p2     = 1'b0;
      streak = 0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [6:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("cycle", dut_vec(), e);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      #1 rst_n = 1'b0;
      #2 chk("power_on_reset", dut_vec(), 7'b0010000);
      #9 rst_n = 1'b1;

      // lock-up from cold
      repeat (3) step(1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0);

      // one-cycle soft reset in RUN
      step(1'b1, 1'b1);
      repeat (16) step(1'b1, 1'b0);

      // lock loss and relock
      repeat (4) step(1'b0, 1'b0);
      repeat (30) step(1'b1, 1'b0);

      // asynchronous reset mid-RUN, then relock
      async_reset();
      repeat (25) step(1'b1, 1'b0);

      // single-cycle lock glitch partway through STABLE
      repeat (3) step(1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      repeat (25) step(1'b1, 1'b0);

      // soft reset held while lock falls
      repeat (3) step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      repeat (20) step(1'b1, 1'b0);

      // random lock drops and soft resets
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) >= 2, $urandom_range(0, 29) == 0);
      end

      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
